// File: rtl/softmax_exp_prep.sv
// Row-buffered range reduction ahead of the 2^x approximator: buffers one row of
// scores, tracks the row max, then replays (x - max) * log2(e) as fraction + shift.
module softmax_exp_prep #(
    parameter int ROW_MAX = 64,
    parameter int DW      = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_VALID,
    input  logic [DW-1:0] I_DATA,
    input  logic          I_LAST,
    output logic          O_READY,
    output logic          O_VALID,
    input  logic          I_READY,
    output logic [12:0]   O_VI,
    output logic [3:0]    O_SHIFT,
    output logic          O_LAST,
    output logic          O_OVF
);
    localparam int PW = $clog2(ROW_MAX + 1);
    localparam int AW = $clog2(ROW_MAX);
    localparam logic signed [31:0] LOG2E = 32'sd11819;

    typedef enum logic {LOAD, EMIT} state_t;
    state_t state_q, state_d;

    logic signed [DW-1:0] mem [ROW_MAX];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic signed [DW-1:0] max_q;

    logic                 accept, trunc, row_end, out_load, out_done;
    logic signed [DW-1:0] x;
    logic signed [DW:0]   d;
    logic signed [31:0]   p, y, n;
    logic [12:0]          f_raw, f;

    assign O_READY = (state_q == LOAD);

    always_comb begin
        state_d  = state_q;
        accept   = I_VALID && (state_q == LOAD);
        trunc    = accept && !I_LAST && (wr_ptr == PW'(ROW_MAX - 1));
        row_end  = accept && (I_LAST || (wr_ptr == PW'(ROW_MAX - 1)));
        out_load = (state_q == EMIT) && (!O_VALID || I_READY) && (rd_ptr < wr_ptr);
        out_done = O_VALID && I_READY && O_LAST;
        case (state_q)
            LOAD:    if (row_end)  state_d = EMIT;
            EMIT:    if (out_done) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // d <= 0 always, so y/n are negative; the floor shifts split y into
    // a non-negative fraction and an integer part whose negation is the shift.
    always_comb begin
        x     = mem[rd_ptr[AW-1:0]];
        d     = (DW+1)'(x) - (DW+1)'(max_q);
        p     = 32'(d) * LOG2E;
        y     = p >>> 13;
        n     = y >>> 13;
        f_raw = y[12:0];
        f     = f_raw;
        if (f_raw == 13'd2166)
            f = 13'd2167;
        else if (f_raw == 13'd8191)
            f = 13'd8190;
    end

    always_ff @(posedge I_CLK) begin
        if (accept)
            mem[wr_ptr[AW-1:0]] <= I_DATA;
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state_q <= LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            max_q   <= '0;
            O_VALID <= 1'b0;
            O_VI    <= '0;
            O_SHIFT <= '0;
            O_LAST  <= 1'b0;
            O_OVF   <= 1'b0;
        end else begin
            state_q <= state_d;
            O_OVF   <= trunc;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (wr_ptr == '0 || $signed(I_DATA) > max_q)
                    max_q <= I_DATA;
            end
            // wr_ptr doubles as the row count while emitting
            if (out_done) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                O_VALID <= 1'b0;
            end else if (out_load) begin
                O_VALID <= 1'b1;
                O_VI    <= f;
                O_SHIFT <= 4'(-n);
                O_LAST  <= (rd_ptr == wr_ptr - PW'(1));
                rd_ptr  <= rd_ptr + PW'(1);
            end else if (I_READY) begin
                O_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: doc/softmax_exp_prep.md
# softmax_exp_prep

Row-buffered range-reduction stage that feeds the piecewise 2^x approximation in the softmax datapath. It accepts one row of attention scores, finds the row maximum, then replays the row as d = x − max scaled by log2(e). Each output carries a 13-bit fractional code for the 2^x approximator and an integer right-shift amount for the downstream scaler. Input and output use valid/ready streams with full backpressure on the output side.

## Interface
- ROW_MAX, 64: maximum scores per row (buffer depth); ≥ 2.
- DW, 16: score width, signed fixed point, 13 fractional bits (0x2000 = 1.0).
- I_CLK  in  1  clock; all logic on rising edge.
- I_RST_N  in  1  synchronous, active-low reset.
- I_VALID  in  1  input score valid.
- I_DATA  in  DW  input score, signed.
- I_LAST  in  1  marks the final score of the row.
- O_READY  out  1  stage can accept a score.
- O_VALID  out  1  output beat valid.
- I_READY  in  1  downstream accepts the output beat.
- O_VI  out  13  fractional code f, unsigned, 2^(f/8192).
- O_SHIFT  out  4  right-shift amount s, result = 2^(f/8192) >> s; range 0..12.
- O_LAST  out  1  marks the final output of the row.
- O_OVF  out  1  one-cycle pulse when a row is truncated at ROW_MAX.

## Operation
- Two-state FSM: LOAD (reset state) and EMIT.
- O_READY = (state == LOAD). In EMIT, input is ignored.
- LOAD: on I_VALID & O_READY, write I_DATA to buffer[wr_ptr], increment wr_ptr, update running max.
  - The first beat of a row loads max unconditionally.
  - Later beats use max = (x > max) ? x : max, signed compare.
- LOAD → EMIT when the accepted beat has I_LAST, or when it is beat number ROW_MAX.
  - Truncation case (ROW_MAX beats without I_LAST): that beat is treated as last and O_OVF pulses the following cycle.
  - Beats after truncation belong to the next row.
- EMIT: the output register loads the next buffer entry whenever (!O_VALID | I_READY) and rd_ptr < count.
- EMIT → LOAD on the handshake of the beat with O_LAST. Pointers and count clear on this transition.
- Arithmetic per element:
  - d = x − max, 17-bit signed, always ≤ 0.
  - p = d × 11819 (log2(e) × 8192, rounded), 32-bit signed.
  - y = p >>> 13 (arithmetic, floor).
  - n = y >>> 13. f = y[12:0]. s = −n.
  - With DW = 16, s never exceeds 12; no saturation logic.
- Code remap for the 2^x approximator's uncovered codes: f = 2166 → 2167; f = 8191 → 8190. No other codes change.
- O_LAST = 1 on the output beat for buffer index count − 1.

## Timing
- Reset: state = LOAD, O_VALID = 0, O_VI = 0, O_SHIFT = 0, O_LAST = 0, O_OVF = 0, pointers and max cleared. O_READY = 1 the cycle after reset deasserts.
- Input throughput: 1 score/cycle in LOAD.
- If the last input beat is accepted in cycle t:
  - state = EMIT at t+1; O_READY = 0 from t+1.
  - The first output is loaded at t+1 and O_VALID = 1 at t+2.
- With I_READY held high, outputs stream 1/cycle with no bubbles.
- With I_READY low, O_VI, O_SHIFT, O_LAST and O_VALID hold stable.
- After the O_LAST handshake at cycle u:
  - O_VALID = 0 at u+1 unless refilled; no refill occurs because the row is complete.
  - O_READY = 1 at u+1.
- Row of length 1: emits one beat with f = 0, s = 0, O_LAST = 1.
- Reset mid-row, in either state: the row is discarded, all outputs take reset values on the next edge, and no partial output is produced.
- Rows never overlap. A new row's input waits until the previous row is fully drained.

## Test plan
- Row {0x0000, 0xE000 (−1.0)}, I_READY = 1 → outputs (f = 0, s = 0), then (f = 4565, s = 2, O_LAST); first O_VALID 2 cycles after the I_LAST accept.
- Row {0x2000, 0x6000} → max 3.0; outputs (f = 938, s = 3), then (f = 0, s = 0, O_LAST).
- Row {0x8000, 0x7FFF} → extreme d = −65535 gives (f = 3753, s = 12); the max element gives (f = 0, s = 0).
- Row of 3 equal scores with I_READY toggled 1,0,0,1,… → 3 beats of (0, 0), outputs stable while stalled, O_LAST only on the third, O_READY low until the O_LAST handshake then high the next cycle.
- ROW_MAX + 2 beats with no I_LAST → first ROW_MAX form a row with O_OVF pulsed once; remaining 2 (second with I_LAST) form the next row after the drain.
- Assert I_RST_N = 0 for one cycle mid-EMIT → O_VALID = 0 and O_READY = 1 after release; the next row processes correctly.
